// File: rtl/ex_operand_if.sv
// ID/EX operand-stage bus: decoded instruction in, forwarding taps,
// hold/flush control, and ALU operand/control bundle out.
interface ex_operand_if #(
    parameter int W  = 32,
    parameter int RA = 5
);
    logic          id_valid;
    logic [W-1:0]  id_rs_data;
    logic [W-1:0]  id_rt_data;
    logic [W-1:0]  id_imm;
    logic [RA-1:0] id_rs;
    logic [RA-1:0] id_rt;
    logic [RA-1:0] id_rd;
    logic [2:0]    id_alu_op;
    logic          id_alu_src;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;

    logic          exmem_reg_write;
    logic [RA-1:0] exmem_rd;
    logic [W-1:0]  exmem_result;
    logic          memwb_reg_write;
    logic [RA-1:0] memwb_rd;
    logic [W-1:0]  memwb_result;

    logic          ex_hold;
    logic          flush;

    logic          id_stall;
    logic          ex_valid;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_in2;
    logic [2:0]    alu_op;
    logic [W-1:0]  ex_store_data;
    logic [RA-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm,
        output id_rs, id_rt, id_rd, id_alu_op, id_alu_src,
        output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        output exmem_reg_write, exmem_rd, exmem_result,
        output memwb_reg_write, memwb_rd, memwb_result,
        output ex_hold, flush,
        input  id_stall, ex_valid, alu_in1, alu_in2, alu_op,
        input  ex_store_data, ex_rd, ex_reg_write,
        input  ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm,
        input  id_rs, id_rt, id_rd, id_alu_op, id_alu_src,
        input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        input  exmem_reg_write, exmem_rd, exmem_result,
        input  memwb_reg_write, memwb_rd, memwb_result,
        input  ex_hold, flush,
        output id_stall, ex_valid, alu_in1, alu_in2, alu_op,
        output ex_store_data, ex_rd, ex_reg_write,
        output ex_mem_read, ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use
// stall/bubble insertion, hold and flush.
module ex_operand_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst,
    ex_operand_if.slave   bus
);
    typedef struct packed {
        logic          valid;
        logic [W-1:0]  rs_data;
        logic [W-1:0]  rt_data;
        logic [W-1:0]  imm;
        logic [RA-1:0] rs;
        logic [RA-1:0] rt;
        logic [RA-1:0] rd;
        logic [2:0]    alu_op;
        logic          alu_src;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } stage_t;

    stage_t        stage_q;
    stage_t        stage_d;
    logic          load_use;
    logic          rt_used;
    logic [W-1:0]  fwd_rs;
    logic [W-1:0]  fwd_rt;

    // Load-use hazard: a load in EX feeding a source the ID instruction reads
    always_comb begin
        rt_used  = ~bus.id_alu_src | bus.id_mem_write;
        load_use = stage_q.valid & stage_q.mem_read
                 & (stage_q.rd != '0) & bus.id_valid
                 & ((stage_q.rd == bus.id_rs)
                    | ((stage_q.rd == bus.id_rt) & rt_used));
    end

    // Next stage contents: flush > hold > load-use bubble > capture ID
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (bus.ex_hold) begin
            stage_d = stage_q;
        end else if (load_use) begin
            stage_d = '0;
        end else begin
            stage_d.valid      = bus.id_valid;
            stage_d.rs_data    = bus.id_rs_data;
            stage_d.rt_data    = bus.id_rt_data;
            stage_d.imm        = bus.id_imm;
            stage_d.rs         = bus.id_rs;
            stage_d.rt         = bus.id_rt;
            stage_d.rd         = bus.id_rd;
            stage_d.alu_op     = bus.id_alu_op;
            stage_d.alu_src    = bus.id_alu_src;
            stage_d.reg_write  = bus.id_reg_write;
            stage_d.mem_read   = bus.id_mem_read;
            stage_d.mem_write  = bus.id_mem_write;
            stage_d.mem_to_reg = bus.id_mem_to_reg;
        end
    end

    // Stage register, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Forwarding per source: EX/MEM beats MEM/WB, r0 never forwarded
    always_comb begin
        fwd_rs = stage_q.rs_data;
        if (bus.exmem_reg_write && bus.exmem_rd != '0
            && bus.exmem_rd == stage_q.rs) begin
            fwd_rs = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd != '0
                     && bus.memwb_rd == stage_q.rs) begin
            fwd_rs = bus.memwb_result;
        end

        fwd_rt = stage_q.rt_data;
        if (bus.exmem_reg_write && bus.exmem_rd != '0
            && bus.exmem_rd == stage_q.rt) begin
            fwd_rt = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd != '0
                     && bus.memwb_rd == stage_q.rt) begin
            fwd_rt = bus.memwb_result;
        end
    end

    // ALU operand select and stage outputs
    always_comb begin
        bus.id_stall      = load_use | bus.ex_hold;
        bus.ex_valid      = stage_q.valid;
        bus.alu_in1       = fwd_rs;
        bus.alu_in2       = stage_q.alu_src ? stage_q.imm : fwd_rt;
        bus.alu_op        = stage_q.alu_op;
        bus.ex_store_data = fwd_rt;
        bus.ex_rd         = stage_q.rd;
        bus.ex_reg_write  = stage_q.reg_write;
        bus.ex_mem_read   = stage_q.mem_read;
        bus.ex_mem_write  = stage_q.mem_write;
        bus.ex_mem_to_reg = stage_q.mem_to_reg;
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage:
// reset, forwarding, load-use, immediate select, hold/flush.
module tb_ex_operand_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_operand_if #(.W(32), .RA(5)) bus ();

    ex_operand_stage #(.W(32), .RA(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [2:0] op,
                          input logic src, input logic rw,
                          input logic mr, input logic mw);
        bus.id_valid      = v;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
        bus.id_rs_data    = rsd;
        bus.id_rt_data    = rtd;
        bus.id_imm        = imm;
        bus.id_alu_op     = op;
        bus.id_alu_src    = src;
        bus.id_reg_write  = rw;
        bus.id_mem_read   = mr;
        bus.id_mem_write  = mw;
        bus.id_mem_to_reg = mr;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd,
                           input logic [31:0] eres, input logic mrw,
                           input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_reg_write = erw;
        bus.exmem_rd        = erd;
        bus.exmem_result    = eres;
        bus.memwb_reg_write = mrw;
        bus.memwb_rd        = mrd;
        bus.memwb_result    = mres;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.ex_hold = 1'b0;
        bus.flush   = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_op", 32'(bus.alu_op), 0);
        chk("rst_in1", bus.alu_in1, 0);
        chk("rst_rd", 32'(bus.ex_rd), 0);
        rst = 1'b0;

        // reset mid-operation
        set_id(1, 1, 2, 2, 32'd5, 0, 0, 3'b001, 0, 1, 0, 0);
        step();
        chk("mid_valid", 32'(bus.ex_valid), 1);
        chk("mid_in1", bus.alu_in1, 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus.ex_valid), 0);
        chk("async_rw", 32'(bus.ex_reg_write), 0);
        chk("async_op", 32'(bus.alu_op), 0);
        rst = 1'b0;

        // forward priority
        set_id(1, 3, 0, 7, 32'd1, 0, 0, 3'b010, 0, 1, 0, 0);
        step();
        chk("fp_op", 32'(bus.alu_op), 2);
        set_fwd(1, 3, 32'h10, 1, 3, 32'h20);
        #1 chk("fp_exmem", bus.alu_in1, 32'h10);
        bus.exmem_reg_write = 1'b0;
        #1 chk("fp_memwb", bus.alu_in1, 32'h20);
        set_fwd(1, 0, 32'h10, 1, 0, 32'h20);
        #1 chk("fp_r0", bus.alu_in1, 32'd1);
        set_fwd(0, 0, 0, 0, 0, 0);

        // load-use on rs
        set_id(1, 1, 0, 4, 0, 0, 32'd8, 3'b000, 1, 1, 1, 0);
        step();
        set_id(1, 4, 6, 5, 32'h99, 32'h3, 0, 3'b000, 0, 1, 0, 0);
        #1 chk("lu_stall", 32'(bus.id_stall), 1);
        step();
        chk("lu_bubble", 32'(bus.ex_valid), 0);
        chk("lu_bub_rw", 32'(bus.ex_reg_write), 0);
        chk("lu_unstall", 32'(bus.id_stall), 0);
        set_fwd(0, 0, 0, 1, 4, 32'h55);
        step();
        chk("lu_valid", 32'(bus.ex_valid), 1);
        chk("lu_rd", 32'(bus.ex_rd), 5);
        chk("lu_fwd", bus.alu_in1, 32'h55);

        // immediate select
        set_id(1, 0, 6, 8, 0, 32'h1, 32'hFFFF_FFFC, 3'b000, 1, 1, 0, 0);
        step();
        set_fwd(0, 0, 0, 1, 6, 32'h7);
        #1 chk("imm_in2", bus.alu_in2, 32'hFFFF_FFFC);
        chk("imm_store", bus.ex_store_data, 32'h7);
        set_fwd(0, 0, 0, 0, 0, 0);

        // rt hazard only matters when rt is really read
        set_id(1, 0, 0, 4, 0, 0, 0, 3'b000, 1, 1, 1, 0);
        step();
        set_id(1, 1, 4, 9, 0, 0, 32'd4, 3'b000, 1, 1, 0, 0);
        #1 chk("imm_nostall", 32'(bus.id_stall), 0);
        bus.id_mem_write = 1'b1;
        bus.id_reg_write = 1'b0;
        #1 chk("sw_stall", 32'(bus.id_stall), 1);
        step();
        chk("sw_bubble", 32'(bus.ex_valid), 0);
        chk("sw_bub_mw", 32'(bus.ex_mem_write), 0);

        // hold then flush
        set_id(1, 2, 0, 9, 32'h123, 0, 0, 3'b011, 0, 1, 0, 0);
        step();
        bus.ex_hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_id(1, 5'(i), 0, 5'(i), i, 0, 0, 3'b100, 0, 0, 1, 1);
            step();
            chk("hold_in1", bus.alu_in1, 32'h123);
            chk("hold_op", 32'(bus.alu_op), 3);
            chk("hold_stall", 32'(bus.id_stall), 1);
        end
        chk("hold_rd", 32'(bus.ex_rd), 9);
        bus.flush = 1'b1;
        #1 chk("fl_stall", 32'(bus.id_stall), 1);
        step();
        chk("fl_valid", 32'(bus.ex_valid), 0);
        chk("fl_rw", 32'(bus.ex_reg_write), 0);
        chk("fl_mr", 32'(bus.ex_mem_read), 0);
        chk("fl_op", 32'(bus.alu_op), 0);
        chk("fl_rd", 32'(bus.ex_rd), 0);
        bus.flush   = 1'b0;
        bus.ex_hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
